// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Shift-add multiply or restoring divide on magnitudes, then a sign fix-up cycle.
module muldiv_ctrl #(
    parameter int unsigned ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  fncode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W     = 32;
    localparam int unsigned N     = W / ITERS_PER_CYCLE;
    localparam int unsigned CNT_W = 5;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [W-1:0]       b_q, b_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               nega_q, nega_d;
    logic               dz_q, dz_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    logic               done_q, done_d;

    logic [2*W-1:0]     acc_step;
    logic [2*W-1:0]     fix_res;
    logic               is_signed;
    logic [W-1:0]       abs_a, abs_b;

    // acc = {partial product, remaining multiplier bits}; add into the upper half then shift right
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : (W+1)'(0));
        return {sum, acc[W-1:1]};
    endfunction

    // acc = {remainder, dividend/quotient}; shift left one bit and try to subtract
    function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] acc, input logic [W-1:0] b);
        logic [W:0]   sh;
        logic [W-1:0] quo;
        sh  = {acc[2*W-1:W], acc[W-1]};
        quo = {acc[W-2:0], 1'b0};
        if (sh >= {1'b0, b}) begin
            return {W'(sh - {1'b0, b}), quo | W'(1)};
        end
        return {sh[W-1:0], quo};
    endfunction

    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < int'(ITERS_PER_CYCLE); i++) begin
            acc_step = div_q ? div_step(acc_step, b_q) : mul_step(acc_step, b_q);
        end
    end

    always_comb begin
        fix_res = acc_q;
        if (!dz_q) begin
            if (div_q) begin
                fix_res[W-1:0]   = neg_q  ? W'(-acc_q[W-1:0])   : acc_q[W-1:0];
                fix_res[2*W-1:W] = nega_q ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
            end else if (neg_q) begin
                fix_res = (2*W)'(-acc_q);
            end
        end
    end

    assign is_signed = (fncode == FN_MULT) || (fncode == FN_DIV);
    assign abs_a     = (is_signed && op_a[W-1]) ? W'(-op_a) : op_a;
    assign abs_b     = (is_signed && op_b[W-1]) ? W'(-op_b) : op_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (fncode)
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            div_d  = (fncode == FN_DIV) || (fncode == FN_DIVU);
                            neg_d  = is_signed && (op_a[W-1] ^ op_b[W-1]);
                            nega_d = is_signed && op_a[W-1];
                            cnt_d  = '0;
                            if (div_d && (op_b == '0)) begin
                                dz_d    = 1'b1;
                                acc_d   = {op_a, {W{1'b1}}};
                                state_d = ST_FIX;
                            end else begin
                                dz_d    = 1'b0;
                                acc_d   = {{W{1'b0}}, div_d ? abs_a : abs_b};
                                b_d     = div_d ? abs_b : abs_a;
                                state_d = ST_RUN;
                            end
                        end
                        FN_MTHI: hi_d = op_a;
                        FN_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = fix_res[2*W-1:W];
                lo_d    = fix_res[W-1:0];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: one instance at 1 step/cycle and one at 4 steps/cycle,
// checked against an arithmetic reference of the HI/LO results and latencies.
module tb_muldiv_ctrl;

    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;

    logic        clk = 1'b0;
    logic        reset, start, en1, en4, start1, start4;
    logic [5:0]  fncode;
    logic [31:0] op_a, op_b;
    logic        busy1, done1, busy4, done4;
    logic [31:0] hi1, lo1, hi4, lo4;
    logic [31:0] m_hi1, m_lo1, m_hi4, m_lo4;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign start1 = start & en1;
    assign start4 = start & en4;

    muldiv_ctrl #(.ITERS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .fncode(fncode), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    muldiv_ctrl #(.ITERS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .fncode(fncode), .op_a(op_a), .op_b(op_b),
        .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    // Reference {hi,lo} after an operation, from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] old);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = old;
        case (fn)
            MULT:  r = 64'(sa * sb);
            MULTU: r = {32'd0, a} * {32'd0, b};
            DIV:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MTHI:  r = {a, old[31:0]};
            MTLO:  r = {old[63:32], a};
            default: r = old;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [5:0] fn, input logic [31:0] b, input int n);
        if ((fn == DIV || fn == DIVU) && b == 0) return 2;
        return n + 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        fncode = fn;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Follow enabled instances from cycle c0 (cycles after the start edge) until their done
    task automatic observe(input int c0, input int exp1, input int exp4,
                           input logic [63:0] r1, input logic [63:0] r4);
        int c, l1, l4, b1, b4;
        c = c0; l1 = 0; l4 = 0; b1 = 0; b4 = 0;
        forever begin
            if (en1 && l1 == 0) begin
                if (busy1) b1++;
                if (done1) l1 = c;
                if (c == exp1 - 1) check("hold1", {hi1, lo1}, {m_hi1, m_lo1});
            end
            if (en4 && l4 == 0) begin
                if (busy4) b4++;
                if (done4) l4 = c;
                if (c == exp4 - 1) check("hold4", {hi4, lo4}, {m_hi4, m_lo4});
            end
            if (((!en1 || l1 != 0) && (!en4 || l4 != 0)) || c >= c0 + 45) break;
            @(posedge clk);
            #1;
            c++;
        end
        if (en1) begin
            check("lat1", 64'(l1), 64'(exp1));
            check("busy_cycles1", 64'(b1), 64'(exp1 - c0));
            check("result1", {hi1, lo1}, r1);
            {m_hi1, m_lo1} = r1;
        end
        if (en4) begin
            check("lat4", 64'(l4), 64'(exp4));
            check("busy_cycles4", 64'(b4), 64'(exp4 - c0));
            check("result4", {hi4, lo4}, r4);
            {m_hi4, m_lo4} = r4;
        end
    endtask

    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r1, r4;
        r1 = ref_res(fn, a, b, {m_hi1, m_lo1});
        r4 = ref_res(fn, a, b, {m_hi4, m_lo4});
        issue(fn, a, b);
        observe(1, lat_of(fn, b, 32), lat_of(fn, b, 8), r1, r4);
    endtask

    initial begin
        int          dcnt;
        logic [63:0] r1;
        logic [5:0]  fn;
        logic [31:0] a, b;

        reset = 1'b1; start = 1'b0; en1 = 1'b1; en4 = 1'b1;
        fncode = '0; op_a = '0; op_b = '0;
        m_hi1 = '0; m_lo1 = '0; m_hi4 = '0; m_lo4 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset1", {30'd0, busy1, done1, hi1, lo1}, 64'd0);
        check("reset4", {30'd0, busy4, done4, hi4, lo4}, 64'd0);

        // MTHI then MTLO on consecutive cycles
        issue(MTHI, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi1", {32'd0, hi1}, {32'd0, 32'hDEAD_BEEF});
        check("mthi_lo1", {32'd0, lo1}, 64'd0);
        issue(MTLO, 32'h1234_5678, 32'h0);
        check("mt_pair1", {hi1, lo1}, {32'hDEAD_BEEF, 32'h1234_5678});
        check("mt_pair4", {hi4, lo4}, {32'hDEAD_BEEF, 32'h1234_5678});
        check("mt_flags", {60'd0, busy1, done1, busy4, done4}, 64'd0);
        @(posedge clk);
        #1;
        check("mt_flags_next", {60'd0, busy1, done1, busy4, done4}, 64'd0);
        m_hi1 = 32'hDEAD_BEEF; m_lo1 = 32'h1234_5678;
        m_hi4 = 32'hDEAD_BEEF; m_lo4 = 32'h1234_5678;

        // Reset during RUN aborts the op and clears HI/LO
        issue(MULT, 32'd12345, 32'd678);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_state1", {31'd0, busy1, hi1, lo1}, 64'd0);
        check("abort_state4", {31'd0, busy4, hi4, lo4}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done1 || done4 || busy1 || busy4) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        m_hi1 = '0; m_lo1 = '0; m_hi4 = '0; m_lo4 = '0;

        // Directed arithmetic corners, issued back-to-back in each done cycle
        run_md(MULT,  32'hFFFF_FFFD, 32'd5);
        check("mult_neg", {hi1, lo1}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_md(MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_big", {hi1, lo1}, {32'h1, 32'hFFFF_FFFE});
        run_md(DIV,   32'hFFFF_FFF9, 32'd2);
        check("div_neg", {hi1, lo1}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_md(DIVU,  32'd100, 32'd7);
        check("divu_small", {hi1, lo1}, {32'd2, 32'd14});
        run_md(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        check("div_wrap", {hi4, lo4}, {32'd0, 32'h8000_0000});
        run_md(DIVU,  32'd5, 32'd0);
        check("divu_zero", {hi4, lo4}, {32'd5, 32'hFFFF_FFFF});
        run_md(DIV,   32'hFFFF_FF00, 32'd0);
        run_md(MULT,  32'h8000_0000, 32'h8000_0000);
        run_md(DIV,   32'd7, 32'hFFFF_FFFE);

        // A start while busy is dropped; only the slow instance sees this sequence
        en4 = 1'b0;
        r1 = ref_res(DIV, 32'd1000, 32'hFFFF_FFFD, {m_hi1, m_lo1});
        issue(DIV, 32'd1000, 32'hFFFF_FFFD);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(MULT, 32'd3, 32'd3);
        observe(6, 34, 0, r1, 64'd0);
        @(posedge clk);
        #1;
        check("dropped_start", {63'd0, busy1}, 64'd0);
        en4 = 1'b1;

        // Unrecognised function codes are ignored
        issue(6'h20, 32'h5555_5555, 32'h1);
        check("ignore_fn1", {31'd0, busy1, hi1, lo1}, {31'd0, 1'b0, m_hi1, m_lo1});
        check("ignore_fn4", {31'd0, busy4, hi4, lo4}, {31'd0, 1'b0, m_hi4, m_lo4});

        // Randomised mult/div traffic
        for (int i = 0; i < 24; i++) begin
            fn = MULT + 6'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_md(fn, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
